mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-ported instruction/data memory between the fetch stage (instruction requests) and the load/store unit (data requests). Each access is a request/grant/response transaction, and only one transaction is outstanding at a time. Data accesses have priority. A streak counter bounds how long fetch can be starved, and a fetch flush drops a stale instruction response so that it is never delivered to fetch.

## Interface
- MAX_LS_STREAK, 4: maximum consecutive LS grants while IF is requesting before IF wins; legal range 1..15.
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- if_req_i  in  1  fetch requests a word read.
- if_addr_i  in  32  fetch address, word aligned.
- if_gnt_o  out  1  fetch request accepted this cycle.
- if_rvalid_o  out  1  instruction response valid.
- if_rdata_o  out  32  instruction word.
- if_raddr_o  out  32  address of the returned instruction.
- if_flush_i  in  1  branch redirect; any in-flight fetch response is dropped.
- ls_req_i  in  1  load/store request.
- ls_we_i  in  1  1 = store.
- ls_addr_i  in  32  data address.
- ls_wdata_i  in  32  store data.
- ls_be_i  in  4  byte enables.
- ls_gnt_o  out  1  LS request accepted.
- ls_rvalid_o  out  1  LS response valid; asserted for stores too, as the completion signal.
- ls_rdata_o  out  32  load data.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  write enable; 0 for fetch.
- mem_addr_o  out  32  address.
- mem_wdata_o  out  32  write data.
- mem_be_o  out  4  byte enables; 4'hF for fetch.
- mem_gnt_i  in  1  memory accepted request.
- mem_rvalid_i  in  1  memory response.
- mem_rdata_i  in  32  response data.

## Operation
- FSM states: IDLE, WAIT_IF, WAIT_LS. Registered state: owner address, drop flag, streak counter (4 bits).
- **Arbitration** (evaluated in IDLE, or in WAIT_x in the cycle mem_rvalid_i is high):
  - If only one requester is active, that requester is selected.
  - If both are active, LS is selected unless streak == MAX_LS_STREAK, in which case IF is selected.
- **Request drive:** mem_req_o = selected requester's req. Mux fields from the selected requester. For IF: mem_we_o = 0, mem_wdata_o = 0, mem_be_o = 4'hF.
- **Grant:** {if,ls}_gnt_o = mem_gnt_i & mem_req_o & selected. The grant is combinational.
- **State on grant:**
  - IF grant: go to WAIT_IF, latch if_addr_i, set drop = if_flush_i.
  - LS grant: go to WAIT_LS.
  - No grant: stay in IDLE, or return to IDLE from a completing WAIT_x.
- **Streak counter:**
  - On an LS grant with if_req_i = 1: increment, saturating at MAX_LS_STREAK.
  - On an LS grant with if_req_i = 0: clear to 0.
  - On an IF grant: clear to 0.
- **WAIT_IF:**
  - if_flush_i = 1 sets drop.
  - On mem_rvalid_i: if_rvalid_o = ~drop & ~if_flush_i, if_rdata_o = mem_rdata_i, if_raddr_o = latched address.
- **WAIT_LS:** on mem_rvalid_i, ls_rvalid_o = 1 and ls_rdata_o = mem_rdata_i.
- **Data routing:** rdata outputs are combinational from mem_rdata_i. When rvalid is 0 they are don't-care.
- **Ignored inputs:**
  - mem_rvalid_i in IDLE is ignored; no rvalid output fires.
  - if_flush_i in IDLE, with no IF grant that cycle, has no effect.
- Requesters hold req and fields stable until granted. The arbiter may switch selection between cycles while mem_gnt_i = 0, but only on the streak rule; the streak does not change without a grant.

## Timing
- **Reset:** rst_ni low asynchronously forces IDLE, streak = 0, drop = 0, owner address = 0.
  - All gnt, rvalid and mem_req_o outputs are 0 during reset, since no requester is selected.
  - An in-flight response arriving after reset is ignored, because the arbiter is in IDLE.
- **Latency:** request to grant is 0 cycles when mem_gnt_i is high. Response latency is set by the memory, minimum 1 cycle after grant.
- **Back-to-back:** a new grant may occur in the same cycle as the previous response. Full throughput is 1 transaction per cycle with a 1-cycle memory.
- **Simultaneous flush and response:** response dropped.
- **Simultaneous flush and IF grant:** that response is dropped when it returns.
- **Flush in WAIT_LS:** no effect on the LS response.
- **No outstanding second request:** no grant is issued in WAIT_x until mem_rvalid_i.

## Test plan
- Reset mid-transaction: IF granted at 0x100, rst_ni pulsed low before the response, mem_rvalid_i arrives after reset -> if_rvalid_o stays 0, state IDLE, all outputs 0.
- Single fetch: if_req_i with addr 0x40, 1-cycle memory returning 0x00000013 -> if_gnt_o in cycle 0; in cycle 1 if_rvalid_o = 1, if_rdata_o = 0x13, if_raddr_o = 0x40.
- Contention with MAX_LS_STREAK = 4: IF and LS requesting continuously, 1-cycle memory -> grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF.
- Store: ls_we_i = 1, addr 0x2000, wdata 0xDEADBEEF, be 4'b0011 -> mem_we_o = 1, mem_be_o = 4'b0011, then ls_rvalid_o = 1 on response.
- Flush cases, 3-cycle memory:
  - Flush 1 cycle after IF grant -> no if_rvalid_o.
  - Flush in the same cycle as the IF grant -> no if_rvalid_o.
  - Next fetch, unflushed -> delivered normally.
- Memory backpressure: mem_gnt_i held low for 5 cycles with only LS requesting -> ls_gnt_o = 0 and the mem fields stay stable; grant follows in the cycle mem_gnt_i rises.

Source files
------------

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose: shares one single-ported memory between the fetch stage (IF,
// word reads) and the load/store unit (LS). Only one transaction is
// outstanding at a time. LS has priority. A streak counter lets IF win after
// MAX_LS_STREAK consecutive LS grants made while IF was waiting. A flush
// drops an in-flight instruction response so fetch never sees it.
//
// Handshake: a requester raises req and holds req plus its fields stable
// until it sees gnt high in the same cycle. gnt is combinational,
// gnt = mem_gnt_i & mem_req_o & selected. The response comes back as a
// one-cycle rvalid pulse, at least one cycle after the grant. A new grant
// may be issued in the same cycle as the previous response.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   if_req_i/if_addr_i      fetch request and word address
//   if_gnt_o                fetch request accepted
//   if_rvalid_o/if_rdata_o  instruction response and data
//   if_raddr_o              address of the returned instruction
//   if_flush_i              drop any in-flight fetch response
//   ls_req_i/ls_we_i/ls_addr_i/ls_wdata_i/ls_be_i   load/store request
//   ls_gnt_o                LS request accepted
//   ls_rvalid_o/ls_rdata_o  LS response; also pulses for stores
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_be_o  memory request
//   mem_gnt_i               memory accepted the request
//   mem_rvalid_i/mem_rdata_i  memory response
//   dbg_state_o             current FSM state (0 IDLE, 1 WAIT_IF, 2 WAIT_LS)
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned MAX_LS_STREAK = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    output logic [31:0] if_raddr_o,
    input  logic        if_flush_i,

    input  logic        ls_req_i,
    input  logic        ls_we_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    input  logic [3:0]  ls_be_i,
    output logic        ls_gnt_o,
    output logic        ls_rvalid_o,
    output logic [31:0] ls_rdata_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_LS = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_addr;
    logic        r_drop;
    logic [3:0]  r_streak;

    logic        w_arb_en;
    logic        w_streak_hit;
    logic        w_sel_if;
    logic        w_sel_ls;
    logic        w_if_gnt;
    logic        w_ls_gnt;

    // Arbitration runs when nothing is outstanding, or in the cycle the
    // outstanding response returns. Qualifying with rst_ni keeps every
    // request/grant output low while reset is asserted.
    assign w_arb_en     = rst_ni & ((r_state == IDLE) | mem_rvalid_i);
    assign w_streak_hit = (r_streak == STREAK_MAX);
    assign w_sel_if     = w_arb_en & if_req_i & (~ls_req_i | w_streak_hit);
    assign w_sel_ls     = w_arb_en & ls_req_i & ~w_sel_if;

    assign w_if_gnt = mem_gnt_i & w_sel_if;
    assign w_ls_gnt = mem_gnt_i & w_sel_ls;

    assign if_gnt_o = w_if_gnt;
    assign ls_gnt_o = w_ls_gnt;

    // Request mux. Fetch is always a full-word read.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        mem_be_o    = 4'h0;
        if (w_sel_ls) begin
            mem_req_o   = 1'b1;
            mem_we_o    = ls_we_i;
            mem_addr_o  = ls_addr_i;
            mem_wdata_o = ls_wdata_i;
            mem_be_o    = ls_be_i;
        end else if (w_sel_if) begin
            mem_req_o   = 1'b1;
            mem_addr_o  = if_addr_i;
            mem_be_o    = 4'hF;
        end
    end

    // A flush arriving together with the response still kills it.
    assign if_rvalid_o = rst_ni & (r_state == WAIT_IF) & mem_rvalid_i
                         & ~r_drop & ~if_flush_i;
    assign ls_rvalid_o = rst_ni & (r_state == WAIT_LS) & mem_rvalid_i;
    assign if_rdata_o  = mem_rdata_i;
    assign ls_rdata_o  = mem_rdata_i;
    assign if_raddr_o  = r_addr;

    assign dbg_state_o = r_state;

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        if (w_arb_en) begin
            if (w_if_gnt) begin
                w_state_nxt = WAIT_IF;
            end else if (w_ls_gnt) begin
                w_state_nxt = WAIT_LS;
            end else begin
                w_state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Owner address, drop flag and streak counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr   <= 32'h0;
            r_drop   <= 1'b0;
            r_streak <= 4'h0;
        end else begin
            if (w_if_gnt) begin
                r_addr <= if_addr_i;
            end

            // A fresh IF grant starts a new transaction, so its drop flag
            // is just the flush seen in the grant cycle.
            if (w_if_gnt) begin
                r_drop <= if_flush_i;
            end else if ((r_state == WAIT_IF) && if_flush_i) begin
                r_drop <= 1'b1;
            end

            // The streak counts LS wins only while IF is kept waiting.
            if (w_ls_gnt) begin
                if (!if_req_i) begin
                    r_streak <= 4'h0;
                end else if (!w_streak_hit) begin
                    r_streak <= r_streak + 4'd1;
                end
            end else if (w_if_gnt) begin
                r_streak <= 4'h0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam logic       H      = 1'b1;
    localparam logic       L      = 1'b0;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WIF  = 2'd1;
    localparam logic [1:0] S_WLS  = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_ni;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic [31:0] if_raddr_o;
    logic        if_flush_i;
    logic        ls_req_i;
    logic        ls_we_i;
    logic [31:0] ls_addr_i;
    logic [31:0] ls_wdata_i;
    logic [3:0]  ls_be_i;
    logic        ls_gnt_o;
    logic        ls_rvalid_o;
    logic [31:0] ls_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [1:0]  dbg_state_o;

    mem_arbiter #(.MAX_LS_STREAK(4)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_gnt_o     (if_gnt_o),
        .if_rvalid_o  (if_rvalid_o),
        .if_rdata_o   (if_rdata_o),
        .if_raddr_o   (if_raddr_o),
        .if_flush_i   (if_flush_i),
        .ls_req_i     (ls_req_i),
        .ls_we_i      (ls_we_i),
        .ls_addr_i    (ls_addr_i),
        .ls_wdata_i   (ls_wdata_i),
        .ls_be_i      (ls_be_i),
        .ls_gnt_o     (ls_gnt_o),
        .ls_rvalid_o  (ls_rvalid_o),
        .ls_rdata_o   (ls_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .dbg_state_o  (dbg_state_o)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic        if_req;
        logic        if_flush;
        logic [31:0] if_addr;
        logic        ls_req;
        logic        ls_we;
        logic [31:0] ls_addr;
        logic [31:0] ls_wdata;
        logic [3:0]  ls_be;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
    } in_t;

    typedef struct {
        logic        if_gnt;
        logic        ls_gnt;
        logic        if_rv;
        logic        ls_rv;
        logic        mem_req;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_be;
        logic [31:0] rdata;
        logic [31:0] raddr;
        logic [1:0]  state;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Contention bookkeeping, used only while filling the table.
    logic        c_if_gnt;
    logic        c_prev_if;

    function automatic in_t in_mem(logic flush, logic rv, logic [31:0] rdata);
        return in_t'{L, flush, 32'h0, L, L, 32'h0, 32'h0, 4'h0, H, rv, rdata};
    endfunction

    function automatic exp_t e_none(logic [1:0] s);
        return exp_t'{L, L, L, L, L, L, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, s};
    endfunction

    function automatic exp_t e_if_rv(logic [31:0] rdata, logic [31:0] raddr);
        return exp_t'{L, L, H, L, L, L, 32'h0, 32'h0, 4'h0, rdata, raddr, S_WIF};
    endfunction

    function automatic exp_t e_ls_rv(logic [31:0] rdata);
        return exp_t'{L, L, L, H, L, L, 32'h0, 32'h0, 4'h0, rdata, 32'h0, S_WLS};
    endfunction

    function automatic exp_t e_if_gnt(logic [31:0] addr, logic [1:0] s);
        return exp_t'{H, L, L, L, H, L, addr, 32'h0, 4'hF, 32'h0, 32'h0, s};
    endfunction

    task automatic add(input in_t i, input exp_t e);
        vec_t v;
        v.i = i;
        v.e = e;
        vecs.push_back(v);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input in_t i);
        if_req_i     = i.if_req;
        if_flush_i   = i.if_flush;
        if_addr_i    = i.if_addr;
        ls_req_i     = i.ls_req;
        ls_we_i      = i.ls_we;
        ls_addr_i    = i.ls_addr;
        ls_wdata_i   = i.ls_wdata;
        ls_be_i      = i.ls_be;
        mem_gnt_i    = i.gnt;
        mem_rvalid_i = i.rv;
        mem_rdata_i  = i.rdata;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got 0x%08h, expected 0x%08h",
                     name, idx, act, exp);
        end
    endtask

    task automatic check_vec(input int idx, input exp_t e);
        chk("if_gnt",    idx, 32'(if_gnt_o),    32'(e.if_gnt));
        chk("ls_gnt",    idx, 32'(ls_gnt_o),    32'(e.ls_gnt));
        chk("if_rvalid", idx, 32'(if_rvalid_o), 32'(e.if_rv));
        chk("ls_rvalid", idx, 32'(ls_rvalid_o), 32'(e.ls_rv));
        chk("mem_req",   idx, 32'(mem_req_o),   32'(e.mem_req));
        chk("state",     idx, 32'(dbg_state_o), 32'(e.state));
        if (e.mem_req) begin
            chk("mem_we",    idx, 32'(mem_we_o), 32'(e.mem_we));
            chk("mem_addr",  idx, mem_addr_o,    e.mem_addr);
            chk("mem_wdata", idx, mem_wdata_o,   e.mem_wdata);
            chk("mem_be",    idx, 32'(mem_be_o), 32'(e.mem_be));
        end
        if (e.if_rv) begin
            chk("if_rdata", idx, if_rdata_o, e.rdata);
            chk("if_raddr", idx, if_raddr_o, e.raddr);
        end
        if (e.ls_rv) begin
            chk("ls_rdata", idx, ls_rdata_o, e.rdata);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit
    // later, well before the next rising edge.
    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        drive(v.i);
        #1;
        check_vec(idx, v.e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_ni = 1'b0;
        drive(in_t'{H, L, 32'h40, H, L, 32'h80, 32'h0, 4'hF, H, H, 32'h0});

        // Reset state: outputs stay low even with requests pending.
        @(negedge clk);
        #1;
        check_vec(-1, e_none(S_IDLE));
        chk("rst_raddr", -1, if_raddr_o, 32'h0);

        @(negedge clk);
        rst_ni = 1'b1;
        drive(in_mem(L, L, 32'h0));

        // Single fetch, 1-cycle memory.
        add(in_t'{H, L, 32'h40, L, L, 32'h0, 32'h0, 4'h0, H, L, 32'h0}, e_if_gnt(32'h40, S_IDLE));
        add(in_mem(L, H, 32'h13), e_if_rv(32'h13, 32'h40));
        add(in_mem(L, L, 32'h0), e_none(S_IDLE));

        // Store.
        add(in_t'{L, L, 32'h0, H, H, 32'h2000, 32'hDEADBEEF, 4'b0011, H, L, 32'h0},
            exp_t'{L, H, L, L, H, H, 32'h2000, 32'hDEADBEEF, 4'b0011, 32'h0, 32'h0, S_IDLE});
        add(in_mem(L, H, 32'h55), e_ls_rv(32'h55));

        // Load followed by a fetch granted in the response cycle.
        add(in_t'{L, L, 32'h0, H, L, 32'h3000, 32'h0, 4'hF, H, L, 32'h0},
            exp_t'{L, H, L, L, H, L, 32'h3000, 32'h0, 4'hF, 32'h0, 32'h0, S_IDLE});
        add(in_t'{H, L, 32'h44, L, L, 32'h0, 32'h0, 4'h0, H, H, 32'hCAFEF00D},
            exp_t'{H, L, L, H, H, L, 32'h44, 32'h0, 4'hF, 32'hCAFEF00D, 32'h0, S_WLS});
        add(in_mem(L, H, 32'h00112233), e_if_rv(32'h00112233, 32'h44));

        // rvalid and flush in IDLE are ignored.
        add(in_mem(H, H, 32'hDEAD0000), e_none(S_IDLE));

        // Memory backpressure on a load.
        for (int k = 0; k < 5; k++) begin
            add(in_t'{L, L, 32'h0, H, L, 32'h12345670, 32'h11111111, 4'hF, L, L, 32'h0},
                exp_t'{L, L, L, L, H, L, 32'h12345670, 32'h11111111, 4'hF, 32'h0, 32'h0, S_IDLE});
        end
        add(in_t'{L, L, 32'h0, H, L, 32'h12345670, 32'h11111111, 4'hF, H, L, 32'h0},
            exp_t'{L, H, L, L, H, L, 32'h12345670, 32'h11111111, 4'hF, 32'h0, 32'h0, S_IDLE});
        add(in_mem(L, H, 32'hA5A5A5A5), e_ls_rv(32'hA5A5A5A5));

        // Flush one cycle after the IF grant; LS waits for the response
        // cycle before it can be granted.
        add(in_t'{H, L, 32'h80, L, L, 32'h0, 32'h0, 4'h0, H, L, 32'h0}, e_if_gnt(32'h80, S_IDLE));
        add(in_t'{L, H, 32'h0, H, L, 32'h700, 32'h0, 4'hF, H, L, 32'h0}, e_none(S_WIF));
        add(in_t'{L, L, 32'h0, H, L, 32'h700, 32'h0, 4'hF, H, L, 32'h0}, e_none(S_WIF));
        add(in_t'{L, L, 32'h0, H, L, 32'h700, 32'h0, 4'hF, H, H, 32'h99},
            exp_t'{L, H, L, L, H, L, 32'h700, 32'h0, 4'hF, 32'h0, 32'h0, S_WIF});
        add(in_mem(L, H, 32'h77), e_ls_rv(32'h77));

        // Flush in the same cycle as the IF grant.
        add(in_t'{H, H, 32'h84, L, L, 32'h0, 32'h0, 4'h0, H, L, 32'h0}, e_if_gnt(32'h84, S_IDLE));
        add(in_mem(L, L, 32'h0), e_none(S_WIF));
        add(in_mem(L, L, 32'h0), e_none(S_WIF));
        add(in_mem(L, H, 32'h98), e_none(S_WIF));

        // Next fetch, unflushed.
        add(in_t'{H, L, 32'h88, L, L, 32'h0, 32'h0, 4'h0, H, L, 32'h0}, e_if_gnt(32'h88, S_IDLE));
        add(in_mem(L, L, 32'h0), e_none(S_WIF));
        add(in_mem(L, L, 32'h0), e_none(S_WIF));
        add(in_mem(L, H, 32'h12345678), e_if_rv(32'h12345678, 32'h88));

        // Flush coinciding with the response.
        add(in_t'{H, L, 32'h8C, L, L, 32'h0, 32'h0, 4'h0, H, L, 32'h0}, e_if_gnt(32'h8C, S_IDLE));
        add(in_mem(H, H, 32'h66), e_none(S_WIF));
        add(in_mem(L, L, 32'h0), e_none(S_IDLE));

        // Flush while waiting on LS has no effect.
        add(in_t'{L, L, 32'h0, H, L, 32'h400, 32'h0, 4'hF, H, L, 32'h0},
            exp_t'{L, H, L, L, H, L, 32'h400, 32'h0, 4'hF, 32'h0, 32'h0, S_IDLE});
        add(in_mem(H, H, 32'hBEEF0001), e_ls_rv(32'hBEEF0001));
        add(in_mem(L, L, 32'h0), e_none(S_IDLE));

        // Contention: grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF.
        c_prev_if = L;
        for (int k = 0; k < 10; k++) begin
            c_if_gnt = (k == 4) || (k == 9);
            add(in_t'{H, L, 32'h500, H, L, 32'h600, 32'h0, 4'hF, H, (k > 0), 32'(k)},
                exp_t'{c_if_gnt, ~c_if_gnt, (k > 0) && c_prev_if, (k > 0) && !c_prev_if,
                       H, L, c_if_gnt ? 32'h500 : 32'h600, 32'h0, 4'hF, 32'(k), 32'h500,
                       (k == 0) ? S_IDLE : (c_prev_if ? S_WIF : S_WLS)});
            c_prev_if = c_if_gnt;
        end
        add(in_mem(L, H, 32'hAA), e_if_rv(32'hAA, 32'h500));
        add(in_mem(L, L, 32'h0), e_none(S_IDLE));

        foreach (vecs[n]) begin
            apply(n, vecs[n]);
        end

        // Reset in the middle of a fetch; the late response is ignored.
        @(negedge clk);
        drive(in_t'{H, L, 32'h100, L, L, 32'h0, 32'h0, 4'h0, H, L, 32'h0});
        #1;
        chk("rst_mid_gnt", 100, 32'(if_gnt_o), 32'h1);
        @(posedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_state",  101, 32'(dbg_state_o), 32'(S_IDLE));
        chk("rst_mid_if_gnt", 101, 32'(if_gnt_o),    32'h0);
        chk("rst_mid_memreq", 101, 32'(mem_req_o),   32'h0);
        chk("rst_mid_raddr",  101, if_raddr_o,       32'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        drive(in_mem(L, H, 32'h13));
        #1;
        check_vec(102, e_none(S_IDLE));
        @(negedge clk);
        drive(in_mem(L, L, 32'h0));
        #1;
        check_vec(103, e_none(S_IDLE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
